piso_shifter: RTL and testbench

Parametrised parallel-in/serial-out shifter: the successor to the fixed 4-bit PISO register. Adds configurable width and bit order, a one-word holding buffer for gap-free back-to-back frames, a shift-enable stall input, and a valid/ready load handshake with frame-end and overrun flags. It sits between a parallel word producer and a serial line driver or bit-serial consumer.

---
 rtl/piso_shifter.sv | 106 ++++++++++
 tb/tb_piso_shifter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_shifter.sv
// piso_shifter: parametrised parallel-in/serial-out shifter with a one-word
// holding buffer so that back-to-back frames leave no gap on the serial side.
//
// Parameters:
//   WIDTH     word width in bits (>= 2)
//   MSB_FIRST 1: din[WIDTH-1] goes out first, 0: din[0] goes out first
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   din    in   parallel word offered for serialisation
//   load   in   word-offer strobe, accepted when ready=1
//   ready  out  holding buffer empty, a word can be accepted
//   en     in   shift enable, consumes the current bit when qvalid=1
//   qout   out  current serial bit
//   qvalid out  qout carries a valid bit
//   last   out  qout is the final bit of the current word
//   ovf    out  sticky overrun flag (load while not ready)
module piso_shifter #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    input  logic             en,
    output logic             qout,
    output logic             qvalid,
    output logic             last,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] hbuf;
    logic [CW-1:0]    cnt;
    buf_state_t       hstate;
    logic             ovf_r;

    logic             consume;
    logic             finishing;
    logic             accept;
    logic [WIDTH-1:0] shifted;

    // Outputs decode registers only; no input reaches an output combinationally.
    assign qvalid = (cnt != '0);
    assign last   = (cnt == CW'(1));
    assign qout   = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign ready  = (hstate == BUF_EMPTY);
    assign ovf    = ovf_r;

    assign consume   = en && qvalid;
    assign finishing = consume && last;
    assign accept    = load && ready;

    // Shift toward the output end with zero fill.
    always_comb begin
        shifted = '0;
        if (MSB_FIRST)
            shifted = {sreg[WIDTH-2:0], 1'b0};
        else
            shifted = {1'b0, sreg[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg   <= '0;
            cnt    <= '0;
            hbuf   <= '0;
            hstate <= BUF_EMPTY;
            ovf_r  <= 1'b0;
        end else begin
            if (load && !ready)
                ovf_r <= 1'b1;

            // Shifter: a direct load wins, then the buffered word on the
            // finishing edge, then a plain shift.
            if (accept && (!qvalid || finishing)) begin
                sreg <= din;
                cnt  <= CW'(WIDTH);
            end else if (finishing && hstate == BUF_FULL) begin
                sreg   <= hbuf;
                cnt    <= CW'(WIDTH);
                hstate <= BUF_EMPTY;
            end else if (consume) begin
                sreg <= shifted;
                cnt  <= cnt - CW'(1);
            end

            // Holding buffer: only used while a word is still mid-flight.
            if (accept && qvalid && !finishing) begin
                hbuf   <= din;
                hstate <= BUF_FULL;
            end
        end
    end

endmodule

// File: tb/tb_piso_shifter.sv
// Directed testbench for piso_shifter: one MSB-first and one LSB-first
// instance, WIDTH=8, sharing clock, reset, data and enable.
module tb_piso_shifter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       load_m, load_l;
    logic       en;

    logic ready_m, qout_m, qvalid_m, last_m, ovf_m;
    logic ready_l, qout_l, qvalid_l, last_l, ovf_l;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    piso_shifter #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(din), .load(load_m), .ready(ready_m),
        .en(en), .qout(qout_m), .qvalid(qvalid_m), .last(last_m), .ovf(ovf_m)
    );

    piso_shifter #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .load(load_l), .ready(ready_l),
        .en(en), .qout(qout_l), .qvalid(qvalid_l), .last(last_l), .ovf(ovf_l)
    );

    // Advance to just after the next rising edge; outputs then show the
    // state of the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_m = 1'b0; load_l = 1'b0; en = 1'b1; din = '0;
        #1;
        n_checks++;
        if ({qout_m, qvalid_m, last_m, ready_m, ovf_m} !== 5'b00010) begin
            n_fail++;
            $display("FAIL reset_msb: got %b expected 00010", {qout_m, qvalid_m, last_m, ready_m, ovf_m});
        end
        n_checks++;
        if ({qout_l, qvalid_l, last_l, ready_l, ovf_l} !== 5'b00010) begin
            n_fail++;
            $display("FAIL reset_lsb: got %b expected 00010", {qout_l, qvalid_l, last_l, ready_l, ovf_l});
        end
        tick();
        rst = 1'b0;
        // en high while idle must not start anything
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (qvalid_m !== 1'b0 || ready_m !== 1'b1) begin
                n_fail++;
                $display("FAIL idle_en: qvalid=%b ready=%b expected 0 1", qvalid_m, ready_m);
            end
        end
    endtask

    task automatic test_single_word();
        logic [7:0] exp_bits;
        exp_bits = 8'b1011_0101;  // B5, MSB first
        din = 8'hB5; load_m = 1'b1; en = 1'b1;
        tick();
        load_m = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            n_checks++;
            if (qout_m !== exp_bits[8-c] || qvalid_m !== 1'b1 || last_m !== (c == 8)) begin
                n_fail++;
                $display("FAIL single_c%0d: qout=%b qvalid=%b last=%b expected %b 1 %b",
                         c, qout_m, qvalid_m, last_m, exp_bits[8-c], (c == 8));
            end
            tick();
        end
        n_checks++;
        if (qvalid_m !== 1'b0 || last_m !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: qvalid=%b last=%b expected 0 0", qvalid_m, last_m);
        end
    endtask

    task automatic test_bit_order();
        logic [7:0] exp_bits;
        exp_bits = 8'b1010_1101;  // B5 sent LSB first: 1,0,1,0,1,1,0,1
        din = 8'hB5; load_l = 1'b1; en = 1'b1;
        tick();
        load_l = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            n_checks++;
            if (qout_l !== exp_bits[8-c] || qvalid_l !== 1'b1 || last_l !== (c == 8)) begin
                n_fail++;
                $display("FAIL lsb_c%0d: qout=%b qvalid=%b last=%b expected %b 1 %b",
                         c, qout_l, qvalid_l, last_l, exp_bits[8-c], (c == 8));
            end
            tick();
        end
        n_checks++;
        if (qvalid_l !== 1'b0) begin
            n_fail++;
            $display("FAIL lsb_end: qvalid=%b expected 0", qvalid_l);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream;
        stream = 16'b1010_0101_0011_1100;  // A5 then 3C
        din = 8'hA5; load_m = 1'b1; en = 1'b1;
        tick();
        load_m = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            load_m = (c == 2);
            din    = 8'h3C;
            n_checks++;
            if (qout_m !== stream[16-c] || qvalid_m !== 1'b1 ||
                last_m !== (c == 8 || c == 16) || ready_m !== !(c >= 3 && c <= 8)) begin
                n_fail++;
                $display("FAIL b2b_c%0d: qout=%b qvalid=%b last=%b ready=%b expected %b 1 %b %b",
                         c, qout_m, qvalid_m, last_m, ready_m, stream[16-c],
                         (c == 8 || c == 16), !(c >= 3 && c <= 8));
            end
            tick();
        end
        load_m = 1'b0;
        n_checks++;
        if (qvalid_m !== 1'b0 || ovf_m !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: qvalid=%b ovf=%b expected 0 0", qvalid_m, ovf_m);
        end
    endtask

    task automatic test_stall();
        logic [10:0] exp_q;
        exp_q = 11'b111_1111_0000;  // bit 2 held for three extra cycles
        din = 8'hF0; load_m = 1'b1; en = 1'b1;
        tick();
        load_m = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            en = !(c >= 3 && c <= 5);
            n_checks++;
            if (qout_m !== exp_q[11-c] || qvalid_m !== 1'b1 || last_m !== (c == 11)) begin
                n_fail++;
                $display("FAIL stall_c%0d: qout=%b qvalid=%b last=%b expected %b 1 %b",
                         c, qout_m, qvalid_m, last_m, exp_q[11-c], (c == 11));
            end
            tick();
        end
        en = 1'b1;
        n_checks++;
        if (qvalid_m !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end: qvalid=%b expected 0", qvalid_m);
        end
    endtask

    task automatic test_overrun();
        logic [15:0] stream;
        stream = 16'b1010_0101_0011_1100;  // A5 then 3C; FF must be dropped
        din = 8'hA5; load_m = 1'b1; en = 1'b1;
        tick();
        for (int c = 1; c <= 16; c++) begin
            load_m = (c == 1 || c == 2);
            din    = (c == 1) ? 8'h3C : 8'hFF;
            n_checks++;
            if (qout_m !== stream[16-c] || qvalid_m !== 1'b1 || ovf_m !== (c >= 3)) begin
                n_fail++;
                $display("FAIL ovf_c%0d: qout=%b qvalid=%b ovf=%b expected %b 1 %b",
                         c, qout_m, qvalid_m, ovf_m, stream[16-c], (c >= 3));
            end
            tick();
        end
        load_m = 1'b0;
        tick();
        n_checks++;
        if (qvalid_m !== 1'b0 || ovf_m !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_end: qvalid=%b ovf=%b expected 0 1", qvalid_m, ovf_m);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp_bits;
        exp_bits = 8'b1000_0001;
        din = 8'hB5; load_m = 1'b1; en = 1'b1;
        tick();
        load_m = 1'b1; din = 8'h3C;  // cycle 1: buffer a second word
        tick();
        load_m = 1'b0;
        tick();
        tick();  // cycle 4: three bits consumed
        rst = 1'b1;
        #1;
        n_checks++;
        if ({qout_m, qvalid_m, last_m, ready_m, ovf_m} !== 5'b00010) begin
            n_fail++;
            $display("FAIL rst_mid: got %b expected 00010", {qout_m, qvalid_m, last_m, ready_m, ovf_m});
        end
        #1;
        rst = 1'b0;
        din = 8'h81; load_m = 1'b1;
        tick();
        load_m = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            n_checks++;
            if (qout_m !== exp_bits[8-c] || qvalid_m !== 1'b1 || last_m !== (c == 8)) begin
                n_fail++;
                $display("FAIL rst_reload_c%0d: qout=%b qvalid=%b last=%b expected %b 1 %b",
                         c, qout_m, qvalid_m, last_m, exp_bits[8-c], (c == 8));
            end
            tick();
        end
        n_checks++;
        if (qvalid_m !== 1'b0 || ready_m !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_reload_end: qvalid=%b ready=%b expected 0 1", qvalid_m, ready_m);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_bit_order();
        test_back_to_back();
        test_stall();
        test_overrun();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
